// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - CPU-side fetch and data port bundle for mem_ctrl
interface mem_ctrl_if;
  // instruction-fetch port
  logic        if_ce;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  // MEM-stage data port
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  // pipeline stall requests
  logic        stallreq_if;
  logic        stallreq_mem;

  modport master (
    output if_ce, if_addr, mem_ce, mem_we, mem_addr, mem_sel, mem_wdata,
    input  if_rdata, if_done, mem_rdata, mem_done, stallreq_if, stallreq_mem
  );

  modport slave (
    input  if_ce, if_addr, mem_ce, mem_we, mem_addr, mem_sel, mem_wdata,
    output if_rdata, if_done, mem_rdata, mem_done, stallreq_if, stallreq_mem
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - fetch/data arbiter splitting 32-bit accesses into byte-wide RAM transfers
module mem_ctrl #(
  parameter int ADDR_W     = 17,
  parameter int DATA_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_ctrl_if.slave         cpu,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, FIN, DONE} state_t;

  state_t            state_q, state_d;
  logic              port_q, port_d;          // 1 = data port owns the transaction
  logic [ADDR_W-1:0] base_q, base_d;          // word-aligned RAM base address
  logic [3:0]        rem_q, rem_d;            // lanes still to be issued
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        lane_q, lane_d;          // lane on the RAM bus this cycle
  logic              pend_vld_q, pend_vld_d;  // a read byte arrives this cycle
  logic [1:0]        pend_lane_q, pend_lane_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ram_ce_q, ram_ce_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;

  logic              grant_mem;
  logic [ADDR_W-1:0] req_base;
  logic [3:0]        req_sel;
  logic              req_we;
  logic [31:0]       req_wdata;
  logic              do_issue;
  logic [1:0]        iss_lane;
  logic              unused_addr_bits;

  // Lowest selected lane; lanes go out in ascending order.
  function automatic logic [1:0] low_lane(input logic [3:0] s);
    if (s[0])      return 2'd0;
    else if (s[1]) return 2'd1;
    else if (s[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Request mux: pick the winning port and present its access in a common form.
  always_comb begin
    grant_mem = cpu.mem_ce & ((DATA_FIRST != 0) | ~cpu.if_ce);
    if (grant_mem) begin
      req_base  = {cpu.mem_addr[ADDR_W-1:2], 2'b00};
      req_sel   = cpu.mem_sel;
      req_we    = cpu.mem_we;
      req_wdata = cpu.mem_wdata;
    end else begin
      req_base  = {cpu.if_addr[ADDR_W-1:2], 2'b00};
      req_sel   = 4'b1111;
      req_we    = 1'b0;
      req_wdata = 32'h0;
    end
  end

  // Next-state logic: sequencing, lane issue, read-byte capture and done pulses.
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    base_d      = base_q;
    rem_d       = rem_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    lane_d      = lane_q;
    pend_vld_d  = 1'b0;
    pend_lane_d = pend_lane_q;
    rdata_d     = rdata_q;
    ram_ce_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    do_issue    = 1'b0;
    iss_lane    = 2'd0;

    // RAM read data lags the address by one cycle, so capture the lane issued last cycle.
    if (pend_vld_q) begin
      rdata_d[{pend_lane_q, 3'b000} +: 8] = ram_rdata;
    end

    case (state_q)
      IDLE: begin
        if (cpu.if_ce | cpu.mem_ce) begin
          port_d  = grant_mem;
          base_d  = req_base;
          we_d    = req_we;
          wdata_d = req_wdata;
          rdata_d = 32'h0;
          rem_d   = req_sel;
          if (req_sel == 4'b0000) begin
            state_d    = DONE;
            if_done_d  = ~grant_mem;
            mem_done_d = grant_mem;
          end else begin
            state_d  = XFER;
            do_issue = 1'b1;
            iss_lane = low_lane(req_sel);
          end
        end
      end
      XFER: begin
        pend_vld_d  = ~we_q;
        pend_lane_d = lane_q;
        if (rem_q != 4'b0000) begin
          do_issue = 1'b1;
          iss_lane = low_lane(rem_q);
        end else if (we_q) begin
          state_d    = DONE;
          if_done_d  = ~port_q;
          mem_done_d = port_q;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d    = DONE;
        if_done_d  = ~port_q;
        mem_done_d = port_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Put one lane on the RAM bus for the coming cycle.
    if (do_issue) begin
      lane_d      = iss_lane;
      rem_d       = rem_d & ~(4'b0001 << iss_lane);
      ram_ce_d    = 1'b1;
      ram_we_d    = we_d;
      ram_addr_d  = base_d | ADDR_W'(iss_lane);
      ram_wdata_d = wdata_d[{iss_lane, 3'b000} +: 8];
    end
  end

  // State and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      base_q      <= '0;
      rem_q       <= 4'b0000;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0;
      lane_q      <= 2'd0;
      pend_vld_q  <= 1'b0;
      pend_lane_q <= 2'd0;
      rdata_q     <= 32'h0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 8'h0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      base_q      <= base_d;
      rem_q       <= rem_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      lane_q      <= lane_d;
      pend_vld_q  <= pend_vld_d;
      pend_lane_q <= pend_lane_d;
      rdata_q     <= rdata_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign ram_ce    = ram_ce_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  // Read data is only presented to the port that is completing.
  assign cpu.if_done      = if_done_q;
  assign cpu.mem_done     = mem_done_q;
  assign cpu.if_rdata     = if_done_q  ? rdata_q : 32'h0;
  assign cpu.mem_rdata    = mem_done_q ? rdata_q : 32'h0;
  assign cpu.stallreq_if  = cpu.if_ce  & ~if_done_q;
  assign cpu.stallreq_mem = cpu.mem_ce & ~mem_done_q;

  // Address bits outside the RAM word address are intentionally ignored.
  assign unused_addr_bits = ^{cpu.if_addr[31:ADDR_W], cpu.if_addr[1:0],
                              cpu.mem_addr[31:ADDR_W], cpu.mem_addr[1:0]};

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl with byte RAM model and reference memory
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ram_ce, ram_we;
  logic [16:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  int          cyc = 0;
  int          ram_ce_cnt = 0;
  int          total = 0;
  int          passed = 0;

  mem_ctrl_if bus();

  mem_ctrl #(.ADDR_W(17), .DATA_FIRST(1)) dut (
    .clk(clk), .rst(rst), .cpu(bus),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] ram     [0:131071];
  logic [7:0] ref_mem [0:131071];

  function automatic logic [7:0] init_byte(int i);
    if (i >= 16 && i < 20) return 8'(8'h11 * (i - 15));
    return 8'(i * 37 + 91);
  endfunction

  // synchronous byte RAM, preloaded during reset
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_byte(i);
    end else if (ram_ce) begin
      ram_ce_cnt <= ram_ce_cnt + 1;
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // monitor: every done pulse is matched against the oldest expected response
  always @(negedge clk) begin
    if (rst && (bus.if_done || bus.mem_done)) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: if_done %b mem_done %b with empty scoreboard", bus.if_done, bus.mem_done);
      end else begin
        mon_e = sb.pop_front();
        chk("done_port", {31'h0, bus.mem_done}, {31'h0, mon_e.port});
        chk("rdata", mon_e.port ? bus.mem_rdata : bus.if_rdata, mon_e.data);
        chk("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  function automatic logic [16:0] baddr(input logic [31:0] a, input int k);
    return {a[16:2], 2'b00} + 17'(k);
  endfunction

  // reference: stores update ref_mem, loads read it; latency from the lane count
  task automatic model_access(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rd, output int lat);
    int n;
    n  = $countones(sel);
    rd = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) begin
        if (we) ref_mem[baddr(addr, k)] = wdata[8*k +: 8];
        else    rd[8*k +: 8] = ref_mem[baddr(addr, k)];
      end
    end
    lat = (n == 0) ? 1 : (we ? n + 1 : n + 2);
  endtask

  task automatic push(input bit port, input logic [31:0] data, input int c);
    exp_t e;
    e.port = port;
    e.data = data;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic drive(input bit port, input bit we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      bus.mem_ce = 1'b1; bus.mem_we = we; bus.mem_sel = sel;
      bus.mem_addr = addr; bus.mem_wdata = wdata;
    end else begin
      bus.if_ce = 1'b1; bus.if_addr = addr;
    end
  endtask

  // wait (bounded) for the port's done, then release its request after the done cycle
  task automatic wait_done(input bit port, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (port ? bus.mem_done : bus.if_done) got = 1'b1;
    end
    if (!got) begin
      total++;
      $display("FAIL %s_timeout: no done within 60 cycles", name);
    end
    @(posedge clk); #1;
    if (port) bus.mem_ce = 1'b0;
    else      bus.if_ce  = 1'b0;
  endtask

  task automatic run(input bit port, input bit we, input logic [3:0] sel,
                     input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    int lat;
    model_access(port & we, port ? sel : 4'hF, addr, wdata, rd, lat);
    @(posedge clk); #1;
    drive(port, we, sel, addr, wdata);
    push(port, rd, cyc + lat);
    wait_done(port, "run");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lat, p, ce_before, stall_bad, ndone, mism;
    bit          got_if, drop_mem;

    bus.if_ce = 0; bus.if_addr = 0; bus.mem_ce = 0; bus.mem_we = 0;
    bus.mem_addr = 0; bus.mem_sel = 0; bus.mem_wdata = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_ce", {31'h0, ram_ce}, 32'h0);
    chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
    chk("rst_ram_addr", {15'h0, ram_addr}, 32'h0);
    chk("rst_ram_wdata", {24'h0, ram_wdata}, 32'h0);
    chk("rst_dones", {30'h0, bus.if_done, bus.mem_done}, 32'h0);
    chk("rst_rdata", bus.if_rdata | bus.mem_rdata, 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // 1: word fetch at 0x10
    @(posedge clk); #1;
    p = cyc;
    drive(0, 0, 4'hF, 32'h10, 0);
    push(0, 32'h44332211, p + 6);
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("t1_ram_ce", {31'h0, ram_ce}, 32'h1);
      chk("t1_ram_addr", {15'h0, ram_addr}, 32'h10 + 32'(i - 1));
    end
    wait_done(0, "t1");

    // 2: single-lane store to 0x22
    model_access(1, 4'b0100, 32'h22, 32'h00AB0000, rd, lat);
    @(posedge clk); #1;
    p = cyc;
    drive(1, 1, 4'b0100, 32'h22, 32'h00AB0000);
    push(1, 32'h0, p + 2);
    @(negedge clk);
    @(negedge clk);
    chk("t2_ram_we", {30'h0, ram_ce, ram_we}, 32'h3);
    chk("t2_ram_addr", {15'h0, ram_addr}, 32'h22);
    chk("t2_ram_wdata", {24'h0, ram_wdata}, 32'hAB);
    wait_done(1, "t2");
    chk("t2_ram_neighbours", {ram[32'h23], ram[32'h22], ram[32'h21], ram[32'h20]},
        {init_byte(32'h23), 8'hAB, init_byte(32'h21), init_byte(32'h20)});

    // 3: simultaneous fetch and half-word load; data port wins
    @(posedge clk); #1;
    p = cyc;
    drive(1, 0, 4'b1100, 32'h40, 0);
    drive(0, 0, 4'hF, 32'h10, 0);
    push(1, {ref_mem[32'h43], ref_mem[32'h42], 16'h0}, p + 4);
    push(0, 32'h44332211, p + 11);
    stall_bad = 0; got_if = 0; drop_mem = 0;
    for (int i = 0; i < 40 && !got_if; i++) begin
      @(negedge clk);
      if (!bus.if_done && !bus.stallreq_if) stall_bad++;
      if (bus.mem_done) drop_mem = 1;
      if (bus.if_done) got_if = 1;
      else begin
        @(posedge clk); #1;
        if (drop_mem) bus.mem_ce = 1'b0;
      end
    end
    if (!got_if) begin total++; $display("FAIL t3_timeout: no if_done"); end
    chk("t3_stallreq_if", 32'(stall_bad), 32'h0);
    @(posedge clk); #1 bus.if_ce = 1'b0;

    // 4: load with empty byte select
    ce_before = ram_ce_cnt;
    run(1, 0, 4'b0000, 32'h50, 0);
    chk("t4_no_ram_ce", 32'(ram_ce_cnt), 32'(ce_before));

    // 5: reset during the third byte of a word store, then restart
    @(posedge clk); #1;
    drive(1, 1, 4'hF, 32'h80, 32'hDDCCBBAA);
    repeat (4) @(negedge clk);
    chk("t5_third_byte_addr", {15'h0, ram_addr}, 32'h82);
    #1 rst = 1'b0;
    #1;
    chk("t5_abort_ram", {15'h0, ram_addr, ram_wdata, ram_ce, ram_we}, 32'h0);
    chk("t5_abort_done", {31'h0, bus.mem_done}, 32'h0);
    @(posedge clk); #1;
    chk("t5_partial", {ram[32'h82], ram[32'h81], ram[32'h80]}, {init_byte(32'h82), 8'hBB, 8'hAA});
    rst = 1'b1;
    model_access(1, 4'hF, 32'h80, 32'hDDCCBBAA, rd, lat);
    push(1, 32'h0, cyc + lat);
    wait_done(1, "t5");

    // 6: fetch held across done, address wraps above ADDR_W
    model_access(0, 4'hF, 32'h0002_0004, 0, rd, lat);
    @(posedge clk); #1;
    p = cyc;
    drive(0, 0, 4'hF, 32'h0002_0004, 0);
    push(0, rd, p + 6);
    push(0, rd, p + 13);
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("t6_wrap_addr", {15'h0, ram_addr}, 32'h4 + 32'(i - 1));
    end
    ndone = 0;
    for (int i = 0; i < 40 && ndone < 2; i++) begin
      @(negedge clk);
      if (bus.if_done) ndone++;
    end
    if (ndone < 2) begin total++; $display("FAIL t6_timeout: %0d done pulses, need 2", ndone); end
    @(posedge clk); #1 bus.if_ce = 1'b0;

    // randomized single-port traffic
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, w;
      a = $urandom() & 32'hFFFE_00FF;
      w = $urandom();
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, w);
    end

    // final memory image and scoreboard drain
    repeat (2) @(negedge clk);
    mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk("ram_image", 32'(mism), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
